// File: rtl/game_sequencer_pkg.sv
// Shared types and helpers for the ballplayer game-flow controller.
// State codes double as the LED encoding.
package game_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_PLAYING = 3'd2,
    ST_LOST    = 3'd3,
    ST_OVER    = 3'd4
  } state_e;

  localparam logic [7:0] SCORE_MAX = 8'h99;

  // Saturating two-digit BCD increment
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == SCORE_MAX)
      r = v;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Bundle between the sequencer, the jumping datapath and display logic.
// master = jumping/display side, slave = sequencer.
interface game_sequencer_if;

  logic       hit_flag;
  logic       over_flag;
  logic       stop_flag;
  logic       release_pulse;
  logic       game_en;
  logic [7:0] score_bcd;
  logic [1:0] lives;
  logic [2:0] state;
  logic       over_led;

  modport master (
    output hit_flag, over_flag, stop_flag,
    input  release_pulse, game_en, score_bcd,
    input  lives, state, over_led
  );

  modport slave (
    input  hit_flag, over_flag, stop_flag,
    output release_pulse, game_en, score_bcd,
    output lives, state, over_led
  );

endinterface

// File: rtl/game_sequencer_btn_debounce.sv
// Active-low button conditioner: 2-FF sync, stability counter,
// one-cycle pulse on the debounced falling edge.
module btn_debounce #(
  parameter int DB_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DB_CYC + 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn_n};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYC - 1)) begin
        // DB_CYC-th consecutive differing sample
        level <= sync[1];
        cnt   <= '0;
        press <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: launch, BCD score, lives and game-over
// sequencing around the jumping datapath.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int CLK_HZ      = 12_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_MS     = 1500,
  parameter int LIVES_INIT  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  game_sequencer_if.slave io
);

  localparam int DB_CYC   = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int HOLD_CYC = CLK_HZ / 1000 * HOLD_MS;
  localparam int HW       = $clog2(HOLD_CYC + 1);

  logic press;

  btn_debounce #(
    .DB_CYC (DB_CYC)
  ) u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_n),
    .press (press)
  );

  // {stop, over, hit}
  logic [2:0] f_s1, f_s2;
  logic [1:0] f_q;
  logic       hit_rise, over_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_s1 <= '0;
      f_s2 <= '0;
      f_q  <= '0;
    end else begin
      f_s1 <= {io.stop_flag, io.over_flag, io.hit_flag};
      f_s2 <= f_s1;
      f_q  <= f_s2[1:0];
    end
  end

  assign hit_rise  = f_s2[0] & ~f_q[0];
  assign over_rise = f_s2[1] & ~f_q[1];

  state_e          state_q, state_d;
  logic [7:0]      score_q, score_d;
  logic [1:0]      lives_q, lives_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            rel_d;

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    hold_d  = '0;
    rel_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (press) begin
          state_d = ST_ARMED;
          score_d = 8'h00;
          lives_d = 2'(LIVES_INIT);
        end
      end
      ST_ARMED: begin
        if (press) begin
          state_d = ST_PLAYING;
          rel_d   = 1'b1;
        end
      end
      ST_PLAYING: begin
        // a loss in the same cycle as a hit discards the hit
        if (over_rise) begin
          lives_d = lives_q - 2'd1;
          state_d = (lives_q == 2'd1) ? ST_OVER : ST_LOST;
        end else if (hit_rise) begin
          score_d = bcd_inc(score_q);
        end
      end
      ST_LOST: begin
        if (hold_q == HW'(HOLD_CYC - 1))
          state_d = ST_ARMED;
        else
          hold_d = hold_q + 1'b1;
      end
      ST_OVER: begin
        if (press) begin
          state_d = ST_IDLE;
          score_d = 8'h00;
          lives_d = 2'(LIVES_INIT);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic rel_q, en_q, led_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      score_q <= 8'h00;
      lives_q <= 2'(LIVES_INIT);
      hold_q  <= '0;
      rel_q   <= 1'b0;
      en_q    <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      lives_q <= lives_d;
      hold_q  <= hold_d;
      rel_q   <= rel_d;
      en_q    <= (state_d == ST_PLAYING);
      led_q   <= (state_d == ST_OVER);
    end
  end

  assign io.release_pulse = rel_q;
  assign io.game_en       = en_q;
  assign io.score_bcd     = score_q;
  assign io.lives         = lives_q;
  assign io.state         = state_q;
  assign io.over_led      = led_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with shortened timing:
// DB_CYC=4, HOLD_CYC=8, three lives.
module tb_game_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   rel_cnt = 0;

  game_sequencer_if bus ();

  game_sequencer #(
    .CLK_HZ      (1000),
    .DEBOUNCE_MS (4),
    .HOLD_MS     (8),
    .LIVES_INIT  (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_n),
    .io    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (bus.release_pulse) rel_cnt++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_btn(input int low);
    btn_n = 1'b0;
    cyc(low);
    btn_n = 1'b1;
    cyc(10);
  endtask

  task automatic hit();
    bus.hit_flag = 1'b1;
    cyc(2);
    bus.hit_flag = 1'b0;
    cyc(4);
  endtask

  task automatic wait_state(input int s, input int budget, input string tag);
    int n = 0;
    while (bus.state != 3'(s) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, bus.state, s);
  endtask

  task automatic lose(input int s, input string tag);
    bus.over_flag = 1'b1;
    wait_state(s, 10, tag);
    bus.over_flag = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    btn_n = 1'b1;
    bus.hit_flag  = 1'b0;
    bus.over_flag = 1'b0;
    bus.stop_flag = 1'b1;
    cyc(3);
    chk("rst_state", bus.state, 0);
    chk("rst_score", bus.score_bcd, 8'h00);
    chk("rst_lives", bus.lives, 3);
    chk("rst_en", bus.game_en, 0);
    chk("rst_led", bus.over_led, 0);
    rst_n = 1'b1;
    cyc(3);

    for (int g = 1; g <= 3; g++) begin
      push_btn(g);
      chk($sformatf("glitch%0d", g), bus.state, 0);
    end

    push_btn(10);
    chk("armed", bus.state, 1);
    chk("armed_rel", rel_cnt, 0);
    push_btn(10);
    chk("play_state", bus.state, 2);
    chk("rel_once", rel_cnt, 1);
    chk("play_en", bus.game_en, 1);

    for (int i = 0; i < 12; i++) hit();
    chk("score12", bus.score_bcd, 8'h12);

    lose(3, "lost1");
    chk("lives2", bus.lives, 2);
    chk("lost_en", bus.game_en, 0);
    n = 0;
    while (bus.state == 3'd3 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("hold_len", n, 8);
    chk("rearm", bus.state, 1);
    chk("keep12", bus.score_bcd, 8'h12);
    hit();
    chk("armed_hit", bus.score_bcd, 8'h12);

    push_btn(10);
    chk("play2", bus.state, 2);
    lose(3, "lost2");
    chk("lives1", bus.lives, 1);
    hit();
    chk("lost_hit", bus.score_bcd, 8'h12);
    wait_state(1, 20, "rearm2");

    push_btn(10);
    chk("play3", bus.state, 2);
    chk("rel_three", rel_cnt, 3);
    for (int i = 0; i < 86; i++) hit();
    chk("score98", bus.score_bcd, 8'h98);
    for (int i = 0; i < 3; i++) hit();
    chk("score_sat", bus.score_bcd, 8'h99);

    lose(4, "over");
    chk("lives0", bus.lives, 0);
    chk("over_led", bus.over_led, 1);
    hit();
    chk("over_hit", bus.score_bcd, 8'h99);
    push_btn(10);
    chk("idle", bus.state, 0);
    chk("idle_score", bus.score_bcd, 8'h00);
    chk("idle_lives", bus.lives, 3);
    chk("idle_led", bus.over_led, 0);

    push_btn(10);
    push_btn(10);
    chk("play4", bus.state, 2);
    for (int i = 0; i < 5; i++) hit();
    chk("score05", bus.score_bcd, 8'h05);
    bus.hit_flag = 1'b1;
    lose(3, "coll_state");
    bus.hit_flag = 1'b0;
    cyc(4);
    chk("coll_score", bus.score_bcd, 8'h05);
    chk("coll_lives", bus.lives, 2);

    wait_state(1, 20, "rearm3");
    push_btn(10);
    chk("play5", bus.state, 2);
    hit();
    chk("score06", bus.score_bcd, 8'h06);
    rel_cnt = 0;
    btn_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", bus.state, 0);
    chk("arst_score", bus.score_bcd, 8'h00);
    chk("arst_lives", bus.lives, 3);
    chk("arst_en", bus.game_en, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(12);
    btn_n = 1'b1;
    cyc(4);
    chk("arst_norel", rel_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
